router_port_reader: RTL and testbench
=====================================

# router_port_reader

Sink-side consumer for one router output port. It drains a packet from the output FIFO when the synchronizer raises that port's valid, and it forwards header, payload and parity bytes to a downstream sink with backpressure. It checks the packet's XOR parity and reports completion, error or abort. Three instances, one per port, sit between the router output FIFOs and the port clients.

## Interface
Parameters:
- START_DELAY, 2: idle cycles between seeing vld_out and issuing the header read. Legal range 0..27, which keeps the reader inside the synchronizer's 30-cycle soft-reset window.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- vld_out  in  1  FIFO non-empty for this port, from the synchronizer.
- soft_reset  in  1  synchronizer soft reset of this port's FIFO.
- dout  in  8  FIFO read data; valid the cycle after rd_en.
- sink_rdy  in  1  downstream can accept a new read.
- rd_en  out  1  FIFO read strobe.
- pkt_data  out  8  forwarded byte.
- pkt_data_vld  out  1  pkt_data valid.
- pkt_sop  out  1  high with the header byte.
- pkt_done  out  1  one-cycle pulse, packet complete.
- pkt_err  out  1  one-cycle pulse with pkt_done when parity mismatches.
- pkt_abort  out  1  one-cycle pulse, packet abandoned.
- busy  out  1  high in every state except IDLE.

## Operation
Packet format:
- Header byte = {len[7:2], addr[1:0]}.
- Then len payload bytes, len = 0..63.
- Then one parity byte = XOR of header and all payload bytes.

FSM states: IDLE, DELAY, HDR, WAIT_HDR, BODY, CHK.
- IDLE → DELAY when vld_out = 1.
  - With START_DELAY = 0, go straight to HDR.
- DELAY: count START_DELAY cycles, then → HDR.
- HDR: assert rd_en when vld_out & sink_rdy, exactly once, then → WAIT_HDR.
- WAIT_HDR (one cycle):
  - Header byte arrives.
  - Latch len; set remaining = len + 1.
  - Seed the parity accumulator with the header byte.
  - → BODY.
- BODY:
  - rd_en = vld_out & sink_rdy & (remaining_to_issue ≠ 0).
  - Decrement issue count per read.
  - Each returned byte updates the accumulator with XOR.
  - When the parity byte has returned, → CHK.
- CHK (one cycle):
  - pkt_done = 1.
  - pkt_err = 1 when the accumulator, which includes the parity byte, is ≠ 0.
  - → IDLE.

Rules:
- rd_en is combinational from registered state, vld_out, sink_rdy and the issue counter. It is never high in IDLE, DELAY, WAIT_HDR or CHK.
- Forwarding:
  - pkt_data_vld = rd_en delayed by one cycle.
  - pkt_data = dout passes through in that cycle.
  - pkt_sop marks the header byte.
- The sink must accept any in-flight byte. sink_rdy only gates new reads.
- vld_out low mid-packet (FIFO empty): reading stalls. There is no timeout inside this block.
- soft_reset = 1 in any state other than IDLE:
  - Next state is IDLE.
  - pkt_abort pulses.
  - All counters clear.
  - pkt_done and pkt_err stay low.
  - A byte already in flight is dropped, so pkt_data_vld is forced to 0.
- soft_reset in IDLE: no effect, no pulse.
- len = 0: the header is followed directly by the parity byte.

## Timing
- Reset values: state IDLE, all counters 0. Every output is 0: rd_en, pkt_data = 8'h00, pkt_data_vld, pkt_sop, pkt_done, pkt_err, pkt_abort, busy.
- Best case, with vld_out and sink_rdy held high:
  - vld_out seen at cycle 0.
  - Header rd_en at cycle START_DELAY + 1.
  - Header byte on pkt_data one cycle later.
  - BODY issues reads back to back, one per cycle.
  - pkt_done one cycle after the parity byte is forwarded.
  - Total ≈ START_DELAY + len + 5 cycles.
- The next packet may start in the cycle after CHK.

## Configuration
READER_STATS_EN:
- Defined: adds outputs pkt_cnt[15:0], incremented on every pkt_done, and err_cnt[15:0], incremented on pkt_err or pkt_abort.
  - Both counters saturate at 16'hFFFF.
  - Both clear only on rst.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- len = 3, header 8'h0D, payload 8'h11/8'h22/8'h33, parity 8'h0D^8'h11^8'h22^8'h33 = 8'h0D, START_DELAY = 2 → 5 forwarded bytes, pkt_sop on the first, pkt_done = 1, pkt_err = 0, rd_en first high 3 cycles after vld_out.
- Same packet with parity 8'h0C → pkt_done = 1 and pkt_err = 1 in the same cycle.
- len = 0, header 8'h01, parity 8'h01 → 2 bytes forwarded, pkt_done = 1, pkt_err = 0.
- sink_rdy low for 4 cycles mid-payload, then vld_out low for 3 cycles → no rd_en during the stalls, no lost or duplicated bytes, correct pkt_done.
- soft_reset asserted after 2 payload bytes → pkt_abort pulses, busy = 0 next cycle, no pkt_done; the next packet is then read correctly.
- With READER_STATS_EN: 2 good packets, 1 bad and 1 aborted → pkt_cnt = 3, err_cnt = 2.

Source files
------------

// File: rtl/router_port_reader_if.sv
// Handshake bundle between one router output FIFO, its port reader and the downstream sink.
// Optional statistics outputs appear when READER_STATS_EN is defined.
interface router_port_reader_if;
    logic        vld_out;
    logic        soft_reset;
    logic [7:0]  dout;
    logic        sink_rdy;
    logic        rd_en;
    logic [7:0]  pkt_data;
    logic        pkt_data_vld;
    logic        pkt_sop;
    logic        pkt_done;
    logic        pkt_err;
    logic        pkt_abort;
    logic        busy;
`ifdef READER_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;
`endif

    modport master (
        input  vld_out, soft_reset, dout, sink_rdy,
        output rd_en, pkt_data, pkt_data_vld, pkt_sop, pkt_done, pkt_err, pkt_abort, busy
`ifdef READER_STATS_EN
        , output pkt_cnt, err_cnt
`endif
    );

    modport slave (
        output vld_out, soft_reset, dout, sink_rdy,
        input  rd_en, pkt_data, pkt_data_vld, pkt_sop, pkt_done, pkt_err, pkt_abort, busy
`ifdef READER_STATS_EN
        , input pkt_cnt, err_cnt
`endif
    );
endinterface

// File: rtl/router_port_reader.sv
// Drains one packet per vld_out from a router output FIFO, forwards it, checks XOR parity.
// Define READER_STATS_EN to add saturating packet/error counters.
module router_port_reader #(
    parameter int unsigned START_DELAY = 2
) (
    input logic                  clk,
    input logic                  rst,
    router_port_reader_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_DELAY, S_HDR, S_WAIT_HDR, S_BODY, S_CHK
    } state_t;

    localparam logic [4:0] DLY_LAST = 5'((START_DELAY == 0) ? 0 : START_DELAY - 1);

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_dly_cnt;
    logic [6:0] r_issue;
    logic [6:0] r_ret;
    logic [7:0] r_acc;
    logic       r_rd_q;
    logic       r_sop_q;
    logic       w_rd_en;
    logic       w_abort;
    logic       w_done;

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        w_abort = bus.soft_reset && (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE:     if (bus.vld_out) w_next = (START_DELAY == 0) ? S_HDR : S_DELAY;
            S_DELAY:    if (r_dly_cnt == DLY_LAST) w_next = S_HDR;
            S_HDR: begin
                w_rd_en = bus.vld_out && bus.sink_rdy;
                if (w_rd_en) w_next = S_WAIT_HDR;
            end
            S_WAIT_HDR: w_next = S_BODY;
            S_BODY: begin
                w_rd_en = bus.vld_out && bus.sink_rdy && (r_issue != '0);
                // parity byte is the last of len+1 returns after the header
                if (r_rd_q && (r_ret == 7'd1)) w_next = S_CHK;
            end
            S_CHK:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_dly_cnt <= '0;
            r_issue   <= '0;
            r_ret     <= '0;
            r_acc     <= '0;
            r_rd_q    <= 1'b0;
            r_sop_q   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rd_q  <= w_rd_en && !w_abort;
            r_sop_q <= w_rd_en && !w_abort && (r_state == S_HDR);
            if (w_abort) begin
                r_dly_cnt <= '0;
                r_issue   <= '0;
                r_ret     <= '0;
                r_acc     <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE:  r_dly_cnt <= '0;
                    S_DELAY: r_dly_cnt <= r_dly_cnt + 5'd1;
                    S_WAIT_HDR: begin
                        r_dly_cnt <= '0;
                        r_issue   <= {1'b0, bus.dout[7:2]} + 7'd1;
                        r_ret     <= {1'b0, bus.dout[7:2]} + 7'd1;
                        r_acc     <= bus.dout;
                    end
                    S_BODY: begin
                        if (w_rd_en) r_issue <= r_issue - 7'd1;
                        if (r_rd_q) begin
                            r_ret <= r_ret - 7'd1;
                            r_acc <= r_acc ^ bus.dout;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_done           = (r_state == S_CHK) && !w_abort;
    assign bus.rd_en        = w_rd_en;
    // an in-flight byte is dropped when the packet is abandoned
    assign bus.pkt_data_vld = r_rd_q && !w_abort;
    assign bus.pkt_data     = bus.pkt_data_vld ? bus.dout : 8'h00;
    assign bus.pkt_sop      = r_sop_q && !w_abort;
    assign bus.pkt_done     = w_done;
    assign bus.pkt_err      = w_done && (r_acc != 8'h00);
    assign bus.pkt_abort    = w_abort;
    assign bus.busy         = (r_state != S_IDLE);

`ifdef READER_STATS_EN
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_done && (r_pkt_cnt != '1)) r_pkt_cnt <= r_pkt_cnt + 16'd1;
            if ((bus.pkt_err || w_abort) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign bus.pkt_cnt = r_pkt_cnt;
    assign bus.err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_router_port_reader.sv
// Self-checking bench for router_port_reader: FIFO model, directed table, stall/abort sequences, random packets.
// Build with READER_STATS_EN to also check the statistics counters.
module tb_router_port_reader;
    localparam int unsigned SD = 2;

    logic clk;
    logic rst;
    router_port_reader_if bus();

    router_port_reader #(.START_DELAY(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       hdr;
        logic [3:0][7:0]  pay;
        logic [7:0]       par;
        bit               exp_err;
        int unsigned      exp_bytes;
        int               exp_rd_lat;
        int               exp_done_lat;
    } vec_t;

    vec_t tv[4];

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         sop_idx_q[$];
    int cyc, first_rd, done_cyc, done_n, abort_n, proto_n, err_last;
    bit g_rdy, g_gate, g_srst;
    bit s_rd, s_abort, s_done, s_busy, s_dvld;
    logic [15:0] s_vec;
    int n_chk, n_fail;
    int m_pkts, m_errs;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        sop_idx_q.delete();
        cyc = 0; first_rd = -1; done_cyc = -1;
        done_n = 0; abort_n = 0; proto_n = 0; err_last = 0;
    endtask

    task automatic load(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    // one clock: drive at negedge, sample 1ns later, FIFO pops just after posedge
    task automatic tick();
        bus.sink_rdy   = g_rdy;
        bus.soft_reset = g_srst;
        bus.vld_out    = g_gate && (fifo_q.size() != 0);
        #1;
        s_rd    = bus.rd_en;
        s_abort = bus.pkt_abort;
        s_done  = bus.pkt_done;
        s_busy  = bus.busy;
        s_dvld  = bus.pkt_data_vld;
        s_vec   = {bus.rd_en, bus.pkt_data, bus.pkt_data_vld, bus.pkt_sop,
                   bus.pkt_done, bus.pkt_err, bus.pkt_abort, bus.busy};
        if (bus.rd_en && (!bus.vld_out || !bus.sink_rdy || fifo_q.size() == 0)) proto_n++;
        if (bus.pkt_data_vld) begin
            obs_q.push_back(bus.pkt_data);
            if (bus.pkt_sop) sop_idx_q.push_back(obs_q.size() - 1);
        end else if (bus.pkt_sop) proto_n++;
        if (bus.pkt_done) begin
            done_n++;
            done_cyc = cyc;
            err_last = int'(bus.pkt_err);
        end
        if (bus.pkt_err && !bus.pkt_done) proto_n++;
        if (bus.pkt_abort) abort_n++;
        if (bus.rd_en && first_rd < 0) first_rd = cyc;
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() != 0) bus.dout = fifo_q.pop_front();
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to_end(input string name, input int budget, input bit rand_ctl);
        int n;
        n = 0;
        while (done_n == 0 && abort_n == 0 && n < budget) begin
            if (rand_ctl) begin
                g_rdy  = ($urandom_range(0, 99) < 70);
                g_gate = ($urandom_range(0, 99) < 80);
            end
            tick();
            n++;
        end
        chk({name, "_end_seen"}, done_n + abort_n, 1);
        g_rdy = 1'b1; g_gate = 1'b1;
    endtask

    task automatic check_pkt(input string name, input bit exp_err);
        int mism;
        int lim;
        mism = 0;
        lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) if (obs_q[i] != exp_q[i]) mism++;
        chk({name, "_nbytes"}, obs_q.size(), exp_q.size());
        chk({name, "_data"}, mism, 0);
        chk({name, "_sop_cnt"}, sop_idx_q.size(), 1);
        if (sop_idx_q.size() != 0) chk({name, "_sop_pos"}, sop_idx_q[0], 0);
        chk({name, "_done"}, done_n, 1);
        chk({name, "_err"}, err_last, int'(exp_err));
        chk({name, "_abort"}, abort_n, 0);
        chk({name, "_proto"}, proto_n, 0);
        chk({name, "_fifo_left"}, fifo_q.size(), 0);
        exp_q.delete();
        m_pkts++;
        if (exp_err) m_errs++;
    endtask

    task automatic load_vec(input int k);
        int unsigned len;
        len = int'(tv[k].hdr[7:2]);
        load(tv[k].hdr);
        for (int unsigned i = 0; i < len; i++) load(tv[k].pay[i]);
        load(tv[k].par);
    endtask

    initial begin
        tv[0] = '{8'h0D, {8'h00, 8'h33, 8'h22, 8'h11}, 8'h0D, 1'b0, 5, SD + 1, SD + 3 + 5};
        tv[1] = '{8'h0D, {8'h00, 8'h33, 8'h22, 8'h11}, 8'h0C, 1'b1, 5, SD + 1, SD + 3 + 5};
        tv[2] = '{8'h01, {8'h00, 8'h00, 8'h00, 8'h00}, 8'h01, 1'b0, 2, SD + 1, SD + 0 + 5};
        tv[3] = '{8'h0A, {8'h00, 8'h00, 8'h5A, 8'hA5}, 8'hF5, 1'b0, 4, SD + 1, SD + 2 + 5};

        n_chk = 0; n_fail = 0; m_pkts = 0; m_errs = 0;
        g_rdy = 1'b0; g_gate = 1'b1; g_srst = 1'b0;
        bus.vld_out = 1'b0; bus.soft_reset = 1'b0; bus.sink_rdy = 1'b0; bus.dout = 8'h00;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_outs", {bus.rd_en, bus.pkt_data, bus.pkt_data_vld, bus.pkt_sop,
                           bus.pkt_done, bus.pkt_err, bus.pkt_abort, bus.busy}, 0);
        @(negedge clk);
        rst = 1'b1;
        clear_obs();
        tick();
        chk("idle_outs", s_vec, 0);

        g_srst = 1'b1;
        tick();
        chk("idle_srst_abort", s_abort, 0);
        chk("idle_srst_busy", s_busy, 0);
        g_srst = 1'b0;
        g_rdy = 1'b1;

        // directed table, best-case timing
        for (int k = 0; k < 4; k++) begin
            clear_obs();
            load_vec(k);
            chk($sformatf("vec%0d_len", k), exp_q.size(), tv[k].exp_bytes);
            run_to_end($sformatf("vec%0d", k), 200, 1'b0);
            chk($sformatf("vec%0d_rd_lat", k), first_rd, tv[k].exp_rd_lat);
            chk($sformatf("vec%0d_done_lat", k), done_cyc, tv[k].exp_done_lat);
            check_pkt($sformatf("vec%0d", k), tv[k].exp_err);
        end

        // sink stall then FIFO-empty stall mid payload
        begin
            int rd_stall;
            logic [7:0] acc;
            clear_obs();
            acc = 8'h18;
            load(8'h18);
            for (int i = 0; i < 6; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                acc ^= b;
                load(b);
            end
            load(acc);
            for (int n = 0; n < 100 && obs_q.size() < 3; n++) tick();
            rd_stall = 0;
            g_rdy = 1'b0;
            for (int n = 0; n < 4; n++) begin tick(); if (s_rd) rd_stall++; end
            chk("stall_rdy_rd", rd_stall, 0);
            g_rdy = 1'b1; g_gate = 1'b0;
            rd_stall = 0;
            for (int n = 0; n < 3; n++) begin tick(); if (s_rd) rd_stall++; end
            chk("stall_vld_rd", rd_stall, 0);
            g_gate = 1'b1;
            run_to_end("stall", 200, 1'b0);
            check_pkt("stall", 1'b0);
        end

        // soft reset after two payload bytes, then a clean packet
        begin
            logic [7:0] acc;
            clear_obs();
            acc = 8'h15;
            load(8'h15);
            for (int i = 0; i < 5; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                acc ^= b;
                load(b);
            end
            load(acc);
            for (int n = 0; n < 100 && obs_q.size() < 3; n++) tick();
            chk("abort_pre_bytes", obs_q.size(), 3);
            g_srst = 1'b1;
            tick();
            chk("abort_pulse", s_abort, 1);
            chk("abort_no_done", s_done, 0);
            chk("abort_drop_vld", s_dvld, 0);
            fifo_q.delete();
            exp_q.delete();
            tick();
            chk("abort_busy_after", s_busy, 0);
            chk("abort_single_pulse", abort_n, 1);
            chk("abort_done_cnt", done_n, 0);
            g_srst = 1'b0;
            m_errs++;
            clear_obs();
            load_vec(0);
            run_to_end("post_abort", 200, 1'b0);
            chk("post_abort_rd_lat", first_rd, tv[0].exp_rd_lat);
            check_pkt("post_abort", 1'b0);
        end

        // random packets with random backpressure and FIFO gaps
        for (int p = 0; p < 24; p++) begin
            int unsigned len;
            logic [7:0]  acc;
            logic [7:0]  hdr;
            bit          bad;
            clear_obs();
            len = $urandom_range(0, 63);
            hdr = {len[5:0], 2'($urandom)};
            bad = ($urandom_range(0, 3) == 0);
            acc = hdr;
            load(hdr);
            for (int unsigned i = 0; i < len; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                acc ^= b;
                load(b);
            end
            if (bad) acc ^= 8'($urandom_range(1, 255));
            load(acc);
            run_to_end($sformatf("rnd%0d", p), 2000, 1'b1);
            check_pkt($sformatf("rnd%0d", p), bad);
        end

`ifdef READER_STATS_EN
        chk("stats_pkt_cnt", bus.pkt_cnt, m_pkts);
        chk("stats_err_cnt", bus.err_cnt, m_errs);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
